chn_fifo_arbiter: RTL and testbench
===================================

CHN_FIFO_ARBITER -- requirements
Module: chn_fifo_arbiter

Interface
REQ-001 Parameter NUM_CHN, default 2: number of input channels, range 1..16.
REQ-002 Parameter DATA_W, default 16: sample word width, minimum 16.
REQ-003 Parameter FIFO_AW, default 11: per-channel FIFO address width, so depth is 2**FIFO_AW words.
REQ-004 Parameter BURST_LEN, default 256: words per full burst, range 1..256, and BURST_LEN SHALL NOT exceed 2**FIFO_AW.
REQ-005 Port clk, input, 1 bit: the single clock for all logic.
REQ-006 Port reset, input, 1 bit: reset, synchronous to clk and active-high.
REQ-007 Port rst_all_fifo, input, 1 bit: synchronous clear with the same effect as reset.
REQ-008 Port flush, input, 1 bit: makes partially filled channels eligible for service.
REQ-009 Port chn_dataout, input, NUM_CHN*DATA_W bits: channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 Port chn_dataout_en, input, NUM_CHN bits: per-channel write strobe.
REQ-011 Port usb_ext_fifo_ready, input, 1 bit: downstream can accept a word this cycle.
REQ-012 Port out_to_usb_ext_fifo_din, output, DATA_W bits: output word.
REQ-013 Port out_to_usb_ext_fifo_en, output, 1 bit: output word valid.
REQ-014 Port chn_overflow, output, NUM_CHN bits: sticky per-channel overflow flags.
REQ-015 Port busy, output, 1 bit: FSM is not in IDLE.

Function
REQ-016 Each channel SHALL have a show-ahead FIFO; a write on chn_dataout_en[i] SHALL be accepted when that FIFO is not full, including in a cycle where the same FIFO is also read.
REQ-017 A write to a full FIFO SHALL be dropped, SHALL set chn_overflow[i], and SHALL leave the stored data unchanged.
REQ-018 A channel SHALL be eligible when its usedw >= BURST_LEN, or when flush = 1 and its usedw >= 1.
REQ-019 The FSM states SHALL be IDLE, HEADER and BURST.
REQ-020 In IDLE, the FSM SHALL grant the first eligible channel found by round-robin search starting at rr_ptr.
REQ-021 On a grant, the FSM SHALL latch len = min(usedw, BURST_LEN), load the header into the output register, and go to HEADER.
REQ-022 rr_ptr SHALL be set to the granted channel + 1, modulo NUM_CHN.
REQ-023 The header word SHALL be {zeros[DATA_W-1:16], 4'hA, chn_id[3:0], (len-1)[7:0]}.
REQ-024 Output handshake: a word transfers on a clock edge where out_to_usb_ext_fifo_en = 1 and usb_ext_fifo_ready = 1.
REQ-025 While en = 1 and ready = 0, din and en SHALL hold their values.
REQ-026 In HEADER, when the header transfers, the FSM SHALL pop the granted FIFO, load its head word, and go to BURST.
REQ-027 In BURST, each transfer SHALL pop the next word, until len data words have transferred.
REQ-028 In BURST, the output register SHALL load a new word whenever en = 0 or ready = 1.
REQ-029 After the last data word transfers, the FSM SHALL go to IDLE with en = 0, giving at most one idle cycle between bursts.
REQ-030 Latency: when a channel is eligible and the FSM is in IDLE, en SHALL rise with the header in the cycle after eligibility is visible on usedw, which is the edge after the write edge.
REQ-031 With ready held at 1, a burst SHALL produce len+1 consecutive output words.
REQ-032 Deasserting flush mid-burst SHALL NOT change the latched len.
REQ-033 Writes to the granted channel during a burst SHALL be stored and SHALL NOT be included in the current burst beyond len.
REQ-034 A granted FIFO SHALL never be empty when popped; the len latch guarantees this.

Reset
REQ-035 When reset or rst_all_fifo is high at a clock edge, the block SHALL empty all FIFOs and set usedw = 0.
REQ-036 On the same condition, the FSM SHALL go to IDLE, rr_ptr SHALL be 0, out_to_usb_ext_fifo_din SHALL be 0, out_to_usb_ext_fifo_en SHALL be 0, chn_overflow SHALL be 0, and busy SHALL be 0.
REQ-037 A reset during a burst SHALL abort the burst with no further output words.
REQ-038 Writes in the reset cycle SHALL be discarded.

Structure
REQ-039 A shared package SHALL hold the FSM state encoding, HDR_MARK = 4'hA, and the header field offsets.
REQ-040 There SHALL be one sub-module, chn_sync_fifo (parameters DATA_W and FIFO_AW; show-ahead; synchronous clear; empty, full and usedw outputs), instantiated NUM_CHN times.
REQ-041 The round-robin arbiter SHALL be inline logic.

Verification
REQ-042 NUM_CHN=2, BURST_LEN=4, ready=1; write 4 words 0x0001..0x0004 to channel 0 -> out = 0xA003, 0x0001, 0x0002, 0x0003, 0x0004, with the header 1 cycle after the 4th write.
REQ-043 Both channels hold 4 words before the first grant -> bursts in order ch0 header 0xA003, then ch1 header 0xA103; then refill ch1 only -> ch1 served again.
REQ-044 Channel 1 holds 2 words 0x0011 and 0x0012, flush pulsed -> out = 0xA101, 0x0011, 0x0012; channel 0 (empty) is not granted.
REQ-045 Ready low for 3 cycles after word 2 of a burst -> din and en held, and no word is lost or duplicated.
REQ-046 FIFO_AW=2; write 5 words to channel 0 with no read -> chn_overflow = 2'b01 and the 5th word is absent from the output.
REQ-047 rst_all_fifo asserted mid-burst -> next cycle en = 0, busy = 0, usedw = 0, and no header appears until new data arrives.

Source files
------------

// File: rtl/chn_fifo_arbiter_pkg.sv
// Shared definitions for the channel FIFO arbiter: FSM encoding and output
// header layout.
package chn_fifo_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_BURST  = 2'd2
    } fsm_state_e;

    localparam logic [3:0] HDR_MARK     = 4'hA;
    localparam int         HDR_MARK_LSB = 12;
    localparam int         HDR_CHN_LSB  = 8;
    localparam int         HDR_LEN_LSB  = 0;
    localparam int         LEN_W        = 9;

    // Header carries len-1 so that a full 256-word burst still fits in 8 bits.
    function automatic logic [15:0] make_header(input logic [3:0]       chn,
                                                input logic [LEN_W-1:0] len);
        logic [15:0] hdr;
        hdr                        = '0;
        hdr[HDR_MARK_LSB +: 4]     = HDR_MARK;
        hdr[HDR_CHN_LSB +: 4]      = chn;
        hdr[HDR_LEN_LSB +: 8]      = 8'(len - LEN_W'(1));
        return hdr;
    endfunction

endpackage

// File: rtl/chn_fifo_arbiter_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear; dout_o always shows the
// oldest stored word, and a write to a full FIFO is ignored.
module chn_sync_fifo #(
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 11
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [FIFO_AW:0]  usedw_o
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               do_wr;
    logic               do_rd;

    assign full_o  = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usedw_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Fullness is judged on the registered count, so a full FIFO drops a
    // write even when it is being read in the same cycle.
    assign do_wr = wr_en_i & ~full_o;
    assign do_rd = rd_en_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            if (do_wr && !do_rd) begin
                cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
            end else if (!do_wr && do_rd) begin
                cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/chn_fifo_arbiter.sv
// Per-channel FIFOs drained in round-robin bursts onto one output stream;
// each burst is a header word followed by len data words.
module chn_fifo_arbiter
    import chn_fifo_arbiter_pkg::*;
#(
    parameter int NUM_CHN   = 2,
    parameter int DATA_W    = 16,
    parameter int FIFO_AW   = 11,
    parameter int BURST_LEN = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rst_all_fifo,
    input  logic                      flush,
    input  logic [NUM_CHN*DATA_W-1:0] chn_dataout,
    input  logic [NUM_CHN-1:0]        chn_dataout_en,
    input  logic                      usb_ext_fifo_ready,
    output logic [DATA_W-1:0]         out_to_usb_ext_fifo_din,
    output logic                      out_to_usb_ext_fifo_en,
    output logic [NUM_CHN-1:0]        chn_overflow,
    output logic                      busy,
    output logic [1:0]                fsm_state_o
);

    localparam int CHN_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;
    localparam int UW    = FIFO_AW + 1;

    logic                clr;
    logic [DATA_W-1:0]   fifo_dout  [NUM_CHN];
    logic [UW-1:0]       fifo_usedw [NUM_CHN];
    logic [NUM_CHN-1:0]  fifo_full;
    logic [NUM_CHN-1:0]  fifo_empty;
    logic [NUM_CHN-1:0]  pop;
    logic [NUM_CHN-1:0]  elig;

    fsm_state_e          state_q, state_d;
    logic [CHN_W-1:0]    chn_q, chn_d;
    logic [CHN_W-1:0]    rr_q, rr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                en_q, en_d;
    logic [NUM_CHN-1:0]  ovf_q, ovf_d;

    logic                xfer;
    logic                grant_found;
    logic [CHN_W-1:0]    grant_chn;
    logic [CHN_W:0]      rr_sum;
    logic [CHN_W:0]      rr_next_sum;
    logic [UW-1:0]       grant_usedw;
    logic [LEN_W-1:0]    grant_len;

    assign clr = reset | rst_all_fifo;

    for (genvar g = 0; g < NUM_CHN; g++) begin : g_chn
        chn_sync_fifo #(
            .DATA_W  (DATA_W),
            .FIFO_AW (FIFO_AW)
        ) u_fifo (
            .clk     (clk),
            .clr_i   (clr),
            .wr_en_i (chn_dataout_en[g]),
            .din_i   (chn_dataout[g*DATA_W +: DATA_W]),
            .rd_en_i (pop[g]),
            .dout_o  (fifo_dout[g]),
            .empty_o (fifo_empty[g]),
            .full_o  (fifo_full[g]),
            .usedw_o (fifo_usedw[g])
        );

        assign elig[g] = (fifo_usedw[g] >= UW'(BURST_LEN)) ||
                         (flush && (fifo_usedw[g] != '0));
    end

    // Round-robin search: first eligible channel at or after rr_q, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_chn   = '0;
        rr_sum      = '0;
        for (int i = 0; i < NUM_CHN; i++) begin
            rr_sum = {1'b0, rr_q} + (CHN_W + 1)'(i);
            if (rr_sum >= (CHN_W + 1)'(NUM_CHN)) rr_sum = rr_sum - (CHN_W + 1)'(NUM_CHN);
            if (!grant_found && elig[rr_sum[CHN_W-1:0]]) begin
                grant_found = 1'b1;
                grant_chn   = rr_sum[CHN_W-1:0];
            end
        end
    end

    always_comb begin
        grant_usedw = fifo_usedw[grant_chn];
        grant_len   = (grant_usedw >= UW'(BURST_LEN)) ? LEN_W'(BURST_LEN) : LEN_W'(grant_usedw);
        rr_next_sum = {1'b0, grant_chn} + (CHN_W + 1)'(1);
        if (rr_next_sum >= (CHN_W + 1)'(NUM_CHN)) rr_next_sum = rr_next_sum - (CHN_W + 1)'(NUM_CHN);
    end

    assign xfer = en_q & usb_ext_fifo_ready;

    always_comb begin
        state_d = state_q;
        chn_d   = chn_q;
        rr_d    = rr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        en_d    = en_q;
        pop     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    chn_d   = grant_chn;
                    len_d   = grant_len;
                    rr_d    = rr_next_sum[CHN_W-1:0];
                    dout_d  = DATA_W'(make_header(4'(grant_chn), grant_len));
                    en_d    = 1'b1;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    pop[chn_q] = ~fifo_empty[chn_q];
                    dout_d     = fifo_dout[chn_q];
                    cnt_d      = LEN_W'(1);
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                // cnt_q counts data words loaded so far; the one on the output
                // when cnt_q == len_q is the last of the burst.
                if (xfer) begin
                    if (cnt_q == len_q) begin
                        en_d    = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        pop[chn_q] = ~fifo_empty[chn_q];
                        dout_d     = fifo_dout[chn_q];
                        cnt_d      = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ovf_d = ovf_q | (chn_dataout_en & fifo_full);

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            chn_q   <= '0;
            rr_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            en_q    <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            chn_q   <= chn_d;
            rr_q    <= rr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_to_usb_ext_fifo_din = dout_q;
    assign out_to_usb_ext_fifo_en  = en_q;
    assign chn_overflow            = ovf_q;
    assign busy                    = (state_q != ST_IDLE);
    assign fsm_state_o             = state_q;

endmodule

// File: tb/tb_chn_fifo_arbiter.sv
// Directed bench for chn_fifo_arbiter (2 channels, depth 4, burst 4) with a
// queue-based reference model checked every cycle plus literal stream pins.
module tb_chn_fifo_arbiter;

    logic        clk;
    logic        reset;
    logic        rst_all_fifo;
    logic        flush;
    logic [31:0] chn_dataout;
    logic [1:0]  chn_dataout_en;
    logic        usb_ext_fifo_ready;
    logic [15:0] out_din;
    logic        out_en;
    logic [1:0]  chn_overflow;
    logic        busy;
    logic [1:0]  fsm_state;

    chn_fifo_arbiter #(
        .NUM_CHN   (2),
        .DATA_W    (16),
        .FIFO_AW   (2),
        .BURST_LEN (4)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .rst_all_fifo            (rst_all_fifo),
        .flush                   (flush),
        .chn_dataout             (chn_dataout),
        .chn_dataout_en          (chn_dataout_en),
        .usb_ext_fifo_ready      (usb_ext_fifo_ready),
        .out_to_usb_ext_fifo_din (out_din),
        .out_to_usb_ext_fifo_en  (out_en),
        .chn_overflow            (chn_overflow),
        .busy                    (busy),
        .fsm_state_o             (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_pass;
    int          n_total;
    bit          chk_on;
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    logic        obs_en;
    logic [15:0] obs_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_stream(input string name);
        check({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(name, 32'(obs_q[i]), 32'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- reference model ----------------
    // Channel queues hold exactly what a FIFO holds; a word leaves its queue
    // when it is placed on the output, i.e. when the previous word transfers.
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];
    bit          m_en;
    bit          m_busy;
    logic [15:0] m_cur;
    logic [1:0]  m_ovf;
    int          m_rr, m_chn, m_len, m_sent, mc;
    bit          m_found, mf0, mf1;

    function automatic int msize(input int c);
        return (c == 0) ? mq0.size() : mq1.size();
    endfunction

    always @(posedge clk) begin
        if (reset || rst_all_fifo) begin
            mq0.delete();
            mq1.delete();
            m_en = 0; m_busy = 0; m_cur = '0; m_ovf = '0;
            m_rr = 0; m_chn = 0; m_len = 0; m_sent = 0;
        end else begin
            mf0 = (mq0.size() == 4);
            mf1 = (mq1.size() == 4);
            if (m_en && usb_ext_fifo_ready) begin
                m_sent++;
                if (m_sent <= m_len) begin
                    if (m_chn == 0) m_cur = mq0.pop_front();
                    else            m_cur = mq1.pop_front();
                end else begin
                    m_en   = 0;
                    m_busy = 0;
                end
            end else if (!m_busy) begin
                m_found = 0;
                for (int i = 0; i < 2; i++) begin
                    mc = (m_rr + i) % 2;
                    if (!m_found && (msize(mc) >= 4 || (flush && msize(mc) >= 1))) begin
                        m_found = 1;
                        m_chn   = mc;
                    end
                end
                if (m_found) begin
                    m_len  = (msize(m_chn) < 4) ? msize(m_chn) : 4;
                    m_cur  = 16'hA000 | 16'(m_chn << 8) | 16'(m_len - 1);
                    m_en   = 1;
                    m_busy = 1;
                    m_sent = 0;
                    m_rr   = (m_chn + 1) % 2;
                end
            end
            if (chn_dataout_en[0]) begin
                if (mf0) m_ovf[0] = 1'b1;
                else     mq0.push_back(chn_dataout[15:0]);
            end
            if (chn_dataout_en[1]) begin
                if (mf1) m_ovf[1] = 1'b1;
                else     mq1.push_back(chn_dataout[31:16]);
            end
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        obs_en  = out_en;
        obs_din = out_din;
        if (chk_on) begin
            check("en", 32'(out_en), 32'(m_en));
            if (m_en) check("din", 32'(out_din), 32'(m_cur));
            check("busy", 32'(busy), 32'(m_busy));
            check("overflow", 32'(chn_overflow), 32'(m_ovf));
        end
    end

    // Record every word that actually transfers.
    always @(posedge clk) begin
        if (!(reset || rst_all_fifo) && obs_en === 1'b1 && usb_ext_fifo_ready)
            obs_q.push_back(obs_din);
    end

    // ---------------- driver ----------------
    bit nr_rst, nr_rst_all, nr_flush, nr_ready;

    task automatic cyc(input logic [1:0] we, input logic [15:0] d0, input logic [15:0] d1);
        @(negedge clk);
        #1;
        reset              = nr_rst;
        rst_all_fifo       = nr_rst_all;
        flush              = nr_flush;
        usb_ext_fifo_ready = nr_ready;
        chn_dataout_en     = we;
        chn_dataout        = {d1, d0};
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(2'b00, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        nr_rst = 1;
        cyc(2'b00, 16'h0, 16'h0);
        nr_rst = 0;
        cyc(2'b00, 16'h0, 16'h0);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic push_burst(input logic [15:0] hdr, input logic [15:0] base, input int n);
        exp_q.push_back(hdr);
        for (int k = 1; k <= n; k++) exp_q.push_back(base + 16'(k));
    endtask

    logic [15:0] hold_din;

    initial begin
        n_pass = 0; n_total = 0; chk_on = 0;
        reset = 1; rst_all_fifo = 0; flush = 0; usb_ext_fifo_ready = 1;
        chn_dataout = '0; chn_dataout_en = '0;
        nr_rst = 1; nr_rst_all = 0; nr_flush = 0; nr_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk_on = 1;
        check("rst_en", 32'(out_en), 32'h0);
        check("rst_din", 32'(out_din), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overflow", 32'(chn_overflow), 32'h0);
        check("rst_state", 32'(fsm_state), 32'h0);
        nr_rst = 0;
        cyc(2'b00, 16'h0, 16'h0);

        // Single full burst on ch0 and its latency.
        for (int k = 1; k <= 4; k++) cyc(2'b01, 16'(k), 16'h0);
        cyc(2'b00, 16'h0, 16'h0);
        check("lat_pre_en", 32'(out_en), 32'h0);
        cyc(2'b00, 16'h0, 16'h0);
        check("lat_hdr_en", 32'(out_en), 32'h1);
        check("lat_hdr_din", 32'(out_din), 32'hA003);
        idle(8);
        push_burst(16'hA003, 16'h0000, 4);
        check_stream("t1_stream");

        // Both channels full before the first grant, then ch1 refilled.
        do_reset();
        for (int k = 1; k <= 4; k++) cyc(2'b11, 16'h0020 + 16'(k), 16'h0030 + 16'(k));
        idle(20);
        push_burst(16'hA003, 16'h0020, 4);
        push_burst(16'hA103, 16'h0030, 4);
        check_stream("t2_order");
        for (int k = 1; k <= 4; k++) cyc(2'b10, 16'h0, 16'h0040 + 16'(k));
        idle(12);
        push_burst(16'hA103, 16'h0040, 4);
        check_stream("t2_refill");

        // Partial channel only drains on flush; empty ch0 never granted.
        cyc(2'b10, 16'h0, 16'h0011);
        cyc(2'b10, 16'h0, 16'h0012);
        idle(4);
        check_stream("t3_noflush");
        nr_flush = 1;
        cyc(2'b00, 16'h0, 16'h0);
        nr_flush = 0;
        idle(8);
        push_burst(16'hA101, 16'h0010, 2);
        check_stream("t3_flush");

        // Backpressure for three cycles after the second data word.
        do_reset();
        for (int k = 1; k <= 4; k++) cyc(2'b01, 16'h0050 + 16'(k), 16'h0);
        for (int w = 0; w < 30 && obs_q.size() < 3; w++) cyc(2'b00, 16'h0, 16'h0);
        check("t4_reach_word2", 32'(obs_q.size() >= 3), 32'h1);
        nr_ready = 0;
        usb_ext_fifo_ready = 1'b0;
        hold_din = out_din;
        check("t4_hold_start", 32'(hold_din), 32'h0053);
        idle(3);
        check("t4_hold_din", 32'(out_din), 32'h0053);
        check("t4_hold_en", 32'(out_en), 32'h1);
        nr_ready = 1;
        idle(8);
        push_burst(16'hA003, 16'h0050, 4);
        check_stream("t4_stream");

        // Overflow: fifth write to a depth-4 FIFO is dropped.
        do_reset();
        nr_ready = 0;
        for (int k = 1; k <= 5; k++) cyc(2'b01, 16'h0060 + 16'(k), 16'h0);
        cyc(2'b00, 16'h0, 16'h0);
        check("t5_overflow", 32'(chn_overflow), 32'h1);
        nr_ready = 1;
        idle(10);
        push_burst(16'hA003, 16'h0060, 4);
        check_stream("t5_stream");
        check("t5_overflow_sticky", 32'(chn_overflow), 32'h1);

        // Writes to the granted channel mid-burst wait for a later burst.
        do_reset();
        for (int k = 1; k <= 4; k++) cyc(2'b01, 16'h0070 + 16'(k), 16'h0);
        idle(2);
        cyc(2'b01, 16'h0075, 16'h0);
        cyc(2'b01, 16'h0076, 16'h0);
        idle(8);
        push_burst(16'hA003, 16'h0070, 4);
        check_stream("t6_first");
        nr_flush = 1;
        cyc(2'b00, 16'h0, 16'h0);
        nr_flush = 0;
        idle(6);
        push_burst(16'hA001, 16'h0074, 2);
        check_stream("t6_late");

        // rst_all_fifo mid-burst aborts; a write in that cycle is discarded.
        do_reset();
        for (int k = 1; k <= 4; k++) cyc(2'b10, 16'h0, 16'h0080 + 16'(k));
        for (int w = 0; w < 30 && obs_q.size() < 2; w++) cyc(2'b00, 16'h0, 16'h0);
        check("t7_reach_data", 32'(obs_q.size() >= 2), 32'h1);
        nr_rst_all = 1;
        cyc(2'b01, 16'h0099, 16'h0);
        nr_rst_all = 0;
        cyc(2'b00, 16'h0, 16'h0);
        check("t7_abort_en", 32'(out_en), 32'h0);
        check("t7_abort_busy", 32'(busy), 32'h0);
        obs_q.delete();
        exp_q.delete();
        nr_flush = 1;
        idle(2);
        nr_flush = 0;
        idle(5);
        check_stream("t7_empty");
        cyc(2'b01, 16'h0091, 16'h0);
        nr_flush = 1;
        cyc(2'b00, 16'h0, 16'h0);
        nr_flush = 0;
        idle(6);
        push_burst(16'hA000, 16'h0090, 1);
        check_stream("t7_len1");

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
